// File: rtl/inst_mem_arb.sv
// inst_mem_arb: arbitrates a CPU instruction fetch port and a loader/debug
// port onto one synchronous single-port instruction memory (1-cycle read).
// Default build: loader wins contention, and a starvation guard forces a
// fetch grant after STARVE_MAX consecutive denied contended cycles.
// Define INST_ARB_RR_EN for round-robin arbitration on contention instead.
module inst_mem_arb #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_inst,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic grant_f_s;
    logic grant_l_s;

    // Response pipeline: which requester owns the memory data next cycle.
    logic f_pend_q, f_pend_d;
    logic l_pend_q, l_pend_d;
    logic l_rd_q, l_rd_d;

    // Byte-address bits outside the word index are deliberately ignored.
    logic unused_addr_s;
    assign unused_addr_s = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                             ld_addr[31:ADDR_W+2], ld_addr[1:0]};

`ifdef INST_ARB_RR_EN
    // 0: fetch wins the next contention, 1: loader wins it.
    logic rr_q, rr_d;

    // Grant selection: sole requester wins, contention follows the pointer.
    always_comb begin
        grant_f_s = 1'b0;
        grant_l_s = 1'b0;
        rr_d      = rr_q;
        if (rst) begin
            rr_d = 1'b0;
        end else if (if_req && ld_req) begin
            if (!rr_q) begin
                grant_f_s = 1'b1;
                rr_d      = 1'b1;
            end else begin
                grant_l_s = 1'b1;
                rr_d      = 1'b0;
            end
        end else if (if_req) begin
            grant_f_s = 1'b1;
        end else if (ld_req) begin
            grant_l_s = 1'b1;
        end else begin
            grant_f_s = 1'b0;
        end
    end

    // Round-robin pointer register; points to fetch after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    logic [CNT_W-1:0] starve_q, starve_d;

    // Grant selection: loader priority, fetch forced once starved long enough.
    always_comb begin
        grant_f_s = 1'b0;
        grant_l_s = 1'b0;
        starve_d  = starve_q;
        if (rst) begin
            starve_d = '0;
        end else if (if_req && ld_req) begin
            if (starve_q == CNT_W'(STARVE_MAX)) begin
                grant_f_s = 1'b1;
                starve_d  = '0;
            end else begin
                grant_l_s = 1'b1;
                starve_d  = starve_q + CNT_W'(1);
            end
        end else if (if_req) begin
            grant_f_s = 1'b1;
            starve_d  = '0;
        end else if (ld_req) begin
            grant_l_s = 1'b1;
        end else begin
            grant_f_s = 1'b0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // Memory port is driven straight from the winner in its grant cycle.
    always_comb begin
        mem_en    = grant_f_s | grant_l_s;
        mem_we    = grant_l_s & ld_we;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if (grant_f_s) begin
            mem_addr = if_addr[ADDR_W+1:2];
        end else if (grant_l_s) begin
            mem_addr = ld_addr[ADDR_W+1:2];
            if (ld_we) begin
                mem_wdata = ld_wdata;
            end else begin
                mem_wdata = 32'd0;
            end
        end else begin
            mem_addr = '0;
        end
        if_stall = if_req & ~grant_f_s;
    end

    // Next-state of the response pipeline: the current grant is answered next cycle.
    always_comb begin
        f_pend_d = grant_f_s;
        l_pend_d = grant_l_s;
        l_rd_d   = grant_l_s & ~ld_we;
    end

    // Response pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_pend_q <= 1'b0;
            l_pend_q <= 1'b0;
            l_rd_q   <= 1'b0;
        end else begin
            f_pend_q <= f_pend_d;
            l_pend_q <= l_pend_d;
            l_rd_q   <= l_rd_d;
        end
    end

    // Responses are gated by rst so a grant issued just before reset is dropped.
    always_comb begin
        if_valid = f_pend_q & ~rst;
        ld_ack   = l_pend_q & ~rst;
        if (if_valid) begin
            if_inst = mem_rdata;
        end else begin
            if_inst = 32'd0;
        end
        if (ld_ack && l_rd_q) begin
            ld_rdata = mem_rdata;
        end else begin
            ld_rdata = 32'd0;
        end
    end

endmodule

// File: doc/inst_mem_arb.md
INST_MEM_ARB -- requirements
Module: inst_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the instruction memory (1024 words).
REQ-002 SHALL have parameter STARVE_MAX, default 4, number of consecutive denied fetch cycles before fetch is forced.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port if_req, input, 1, CPU fetch request (level).
REQ-006 SHALL have port if_addr, input, 32, fetch byte address; word index = if_addr[ADDR_W+1:2].
REQ-007 SHALL have port if_inst, output, 32, fetched instruction.
REQ-008 SHALL have port if_valid, output, 1, if_inst valid this cycle.
REQ-009 SHALL have port if_stall, output, 1, fetch requested but not granted this cycle.
REQ-010 SHALL have port ld_req, input, 1, loader/debug request (level).
REQ-011 SHALL have port ld_we, input, 1, loader write (1) or readback (0).
REQ-012 SHALL have port ld_addr, input, 32, loader byte address; word index = ld_addr[ADDR_W+1:2].
REQ-013 SHALL have port ld_wdata, input, 32, loader write data.
REQ-014 SHALL have port ld_rdata, output, 32, loader readback data.
REQ-015 SHALL have port ld_ack, output, 1, loader access completed.
REQ-016 SHALL have ports mem_en, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_rdata (input, 32): synchronous single-port memory, read data one cycle after mem_en.

Function
REQ-017 SHALL grant at most one requester per cycle; grant drives mem_en=1 and mem_addr/mem_we/mem_wdata from the winner combinationally in the same cycle.
REQ-018 SHALL consume a request in its grant cycle; a request still high in the following cycle is a new request.
REQ-019 SHALL respond exactly one cycle after grant: fetch grant -> if_valid=1, if_inst=mem_rdata; loader grant -> ld_ack=1, ld_rdata=mem_rdata (read) or don't-care (write).
REQ-020 SHALL sustain one grant per cycle (pipelined; grant N+1 overlaps response of grant N).
REQ-021 SHALL, with no contention, grant the sole requester; with neither requesting, mem_en=0.
REQ-022 SHALL, on contention (default arbitration), grant loader and increment a starvation counter; fetch grant resets the counter to 0.
REQ-023 SHALL force a fetch grant on contention when the counter equals STARVE_MAX, then clear the counter.
REQ-024 SHALL drive if_stall = if_req AND NOT fetch-grant, combinationally.
REQ-025 SHALL never drive mem_we=1 on a fetch grant; fetch never writes memory.
REQ-026 SHALL truncate address bits above ADDR_W+1 and ignore bits [1:0] (word wrap-around).

Reset
REQ-027 SHALL, while rst=1, drive if_valid=0, ld_ack=0, if_inst=0, ld_rdata=0, mem_en=0, mem_we=0, and no grant.
REQ-028 SHALL clear the starvation counter and round-robin pointer (pointer to fetch) on reset.
REQ-029 SHALL discard a grant issued in the cycle before rst asserts: no if_valid/ld_ack in the cycle after.

Configuration
REQ-030 SHALL, when macro INST_ARB_RR_EN is defined, replace REQ-022/023 with round-robin: on contention grant the requester not granted last contention, pointer updated only on contention grants.
REQ-031 SHALL, without INST_ARB_RR_EN, use fixed loader priority with starvation guard (REQ-022/023); no round-robin pointer state exists.

Verification
REQ-032 SHALL cover: if_req=1 only, if_addr=0x00000008, mem word 2=0x08000003 -> if_valid next cycle, if_inst=0x08000003, if_stall=0 throughout.
REQ-033 SHALL cover: ld write addr 0x3A8, data 0x8E110000, then ld read same addr -> mem_we=1 once, ld_ack both cycles after grant, ld_rdata=0x8E110000.
REQ-034 SHALL cover (default build): if_req and ld_req held high 10 cycles -> fetch granted on 5th contended cycle, if_stall high exactly 4 of each 5 cycles.
REQ-035 SHALL cover (INST_ARB_RR_EN): both requests held high 6 cycles -> grants alternate F,L,F,L,F,L starting with fetch after reset.
REQ-036 SHALL cover: fetch granted, rst=1 next cycle -> if_valid=0, all outputs 0; after rst release first if_req grants immediately.
REQ-037 SHALL cover: if_addr=0x00001004, ADDR_W=10 -> mem_addr=0x001 (wrap-around).
